dmem_arbiter: RTL

Two-requester arbiter and sequencer for the single-port synchronous data RAM. It shares the RAM between the CPU MEM-stage port and the UART program-loader write port. The block latches each granted access, drives registered RAM control, and waits out the RAM read latency. It returns one-cycle completion pulses, and it raises `stall_req` to hold the pipeline while a CPU access is outstanding. It sits between the MEM stage's RAM-side outputs and the data RAM; IO-space accesses never reach it.

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing the single-port data RAM between
// the CPU MEM-stage port and the UART program-loader write port.
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              stall_req,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // Handshake: a requester raises req and holds it until its one-cycle
  // completion pulse (cpu_ready / ld_ack); it must drop or change the request
  // at that edge. The request is captured at grant, later changes are ignored.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t              state, state_nxt;
  logic [1:0]          cnt, cnt_nxt;
  logic                last_ld, last_ld_nxt;
  logic                win_ld, win_ld_nxt;
  logic                pick_ld;
  logic [31:0]         cpu_rdata_nxt;
  logic                cpu_ready_nxt, ld_ack_nxt;
  logic                ram_en_nxt, ram_we_nxt;
  logic [ADDR_W-1:0]   ram_addr_nxt;
  logic [31:0]         ram_wdata_nxt;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              ld_addr[31:ADDR_W+2], ld_addr[1:0]};

  assign stall_req = cpu_req & ~cpu_ready;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_ld_nxt   = last_ld;
    win_ld_nxt    = win_ld;
    pick_ld       = 1'b0;
    cpu_rdata_nxt = cpu_rdata;
    cpu_ready_nxt = 1'b0;
    ld_ack_nxt    = 1'b0;
    ram_en_nxt    = 1'b0;
    ram_we_nxt    = 1'b0;
    ram_addr_nxt  = '0;
    ram_wdata_nxt = '0;
    case (state)
      S_IDLE: begin
        if (cpu_req || ld_req) begin
          // On conflict the loader wins only if the CPU was granted last.
          pick_ld       = ld_req && (!cpu_req || !last_ld);
          win_ld_nxt    = pick_ld;
          last_ld_nxt   = pick_ld;
          ram_en_nxt    = 1'b1;
          ram_we_nxt    = pick_ld | cpu_we;
          ram_addr_nxt  = pick_ld ? ld_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
          ram_wdata_nxt = pick_ld ? ld_wdata : (cpu_we ? cpu_wdata : 32'h0);
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ram_we) begin
          cpu_ready_nxt = !win_ld;
          ld_ack_nxt    = win_ld;
          state_nxt     = S_DONE;
        end else begin
          cnt_nxt   = CNT_INIT;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 2'd0) begin
          cpu_rdata_nxt = ram_rdata;
          cpu_ready_nxt = 1'b1;
          state_nxt     = S_DONE;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      last_ld   <= 1'b1;
      win_ld    <= 1'b0;
      cpu_rdata <= 32'h0;
      cpu_ready <= 1'b0;
      ld_ack    <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_ld   <= last_ld_nxt;
      win_ld    <= win_ld_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      cpu_ready <= cpu_ready_nxt;
      ld_ack    <= ld_ack_nxt;
      ram_en    <= ram_en_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
    end
  end

endmodule
